matrix_keypad_scanner: RTL and testbench

- Input-side counterpart of the 8x8 LED matrix display driver: scans an 8x8 key matrix over the same active-low row/column interface.
- Drives one row low at a time and samples the 8 column sense lines.
- Debounces across full scans and reports a single accepted key as a {row,col} code with a valid/ack handshake.
- Sits between the board key matrix and any consumer logic, such as a frame selector for the display.

---
 rtl/matrix_keypad_scanner.sv | 192 +++++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_keypad_scanner.sv
// 8x8 active-low key matrix scanner: row-sequenced column sampling, whole-scan
// debounce, and a single-key {row,col} report with a valid/ack handshake.
module matrix_keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock50MHz,
  input  logic       reset,
  output logic [7:0] row,
  input  logic [7:0] column,
  output logic [5:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       multi_press,
  output logic       overrun
);

  localparam int unsigned      DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_e;
  typedef enum logic {ST_IDLE, ST_HELD} state_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [7:0]       row_q, row_d;
  logic             adv_q, adv_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [5:0]       acc_code_q, acc_code_d;
  scan_res_e        prev_res_q, prev_res_d;
  logic [5:0]       prev_code_q, prev_code_d;
  logic [3:0]       stable_q, stable_d;
  state_e           state_q, state_d;
  logic [5:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             multi_q, multi_d;
  logic             overrun_q, overrun_d;

  logic      terminal;
  logic      scan_end;
  logic      same_res;
  logic      stable_hit;
  scan_res_e scan_res;

  assign terminal = (div_q == DIV_LAST);
  // adv_q marks the cycle after a terminal sample; after row 7 that is the scan evaluation slot
  assign scan_end = adv_q && (row_idx_q == 3'd7);

  always_comb begin
    scan_res = RES_NONE;
    if (acc_cnt_q == 2'd1) begin
      scan_res = RES_SINGLE;
    end else if (acc_cnt_q != 2'd0) begin
      scan_res = RES_MULTI;
    end
  end

  assign same_res = (scan_res == prev_res_q) &&
                    ((scan_res != RES_SINGLE) || (acc_code_q == prev_code_q));

  always_comb begin
    div_d       = terminal ? '0 : div_q + DIV_W'(1);
    adv_d       = terminal;
    row_idx_d   = row_idx_q;
    row_d       = row_q;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    prev_res_d  = prev_res_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_down_d  = key_down_q;
    multi_d     = multi_q;
    overrun_d   = overrun_q;
    stable_hit  = 1'b0;

    if (adv_q) begin
      row_idx_d = row_idx_q + 3'd1;
      row_d     = ~(8'd1 << row_idx_d);
    end

    // Rows arrive in ascending order, so the first hit seen is lowest row then lowest column
    if (scan_end) begin
      acc_cnt_d  = '0;
      acc_code_d = '0;
    end else if (terminal) begin
      for (int unsigned c = 0; c < 8; c++) begin
        if (!column[c]) begin
          if (acc_cnt_d == 2'd0) begin
            acc_code_d = {row_idx_q, 3'(c)};
          end
          if (acc_cnt_d != 2'd2) begin
            acc_cnt_d = acc_cnt_d + 2'd1;
          end
        end
      end
    end

    if (scan_end) begin
      if (same_res) begin
        stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
      end
      prev_res_d  = scan_res;
      prev_code_d = acc_code_q;
      stable_hit  = (stable_d == STABLE_MAX);
    end

    if (key_ack) begin
      key_valid_d = 1'b0;
      multi_d     = 1'b0;
      overrun_d   = 1'b0;
    end

    // Events are applied after the ack so a same-cycle acceptance reloads rather than overruns
    if (stable_hit) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_res == RES_SINGLE) begin
            state_d    = ST_HELD;
            key_down_d = 1'b1;
            if (key_valid_q && !key_ack) begin
              overrun_d = 1'b1;
            end else begin
              key_code_d  = acc_code_q;
              key_valid_d = 1'b1;
            end
          end else if (scan_res == RES_MULTI) begin
            multi_d = 1'b1;
          end
        end
        ST_HELD: begin
          if (scan_res == RES_NONE) begin
            state_d    = ST_IDLE;
            key_down_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      div_q       <= '0;
      row_idx_q   <= '0;
      row_q       <= 8'b1111_1110;
      adv_q       <= 1'b0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      prev_res_q  <= RES_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      adv_q       <= adv_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      prev_res_q  <= prev_res_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      multi_q     <= multi_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row         = row_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign multi_press = multi_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2;
// a 64-bit key map drives column from the active row.
module tb_matrix_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  row;
  logic [7:0]  column;
  logic [5:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_down;
  logic        multi_press;
  logic        overrun;
  logic [63:0] keys;

  int total = 0;
  int bad   = 0;

  matrix_keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clock50MHz (clk),
    .reset      (reset),
    .row        (row),
    .column     (column),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .key_down   (key_down),
    .multi_press(multi_press),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    column = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (row[r] === 1'b0) column = column & ~keys[r*8 +: 8];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: the state right after the last reset edge
  task automatic do_reset();
    reset   = 1'b1;
    key_ack = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] exp_row(input int n);
    int idx;
    idx = (n == 0) ? 0 : ((n - 1) / 4) % 8;
    return ~(8'd1 << idx);
  endfunction

  task automatic test_reset();
    keys = '0;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      total++;
      if (row !== exp_row(n)) begin
        bad++;
        $display("FAIL reset_row cyc=%0d got=%h exp=%h", n, row, exp_row(n));
      end
      total++;
      if ({key_code, key_valid, key_down, multi_press, overrun} !== 10'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d code=%h v=%b d=%b m=%b o=%b exp=all0",
                 n, key_code, key_valid, key_down, multi_press, overrun);
      end
      step(1);
    end
  endtask

  task automatic test_single_ack();
    keys = '0;
    keys[2*8+5] = 1'b1;
    do_reset();
    step(64);
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early cyc=64 key_valid got=%b exp=0", key_valid);
    end
    step(1);
    total++;
    if (key_valid !== 1'b1 || key_code !== 6'h15 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL single_accept cyc=65 v=%b code=%h d=%b exp v=1 code=15 d=1",
               key_valid, key_code, key_down);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    total++;
    if (key_valid !== 1'b0 || key_code !== 6'h15 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL single_ack v=%b code=%h d=%b exp v=0 code=15 d=1",
               key_valid, key_code, key_down);
    end
    keys = '0;
  endtask

  task automatic test_short_press();
    keys = '0;
    keys[2*8+5] = 1'b1;
    do_reset();
    total++;
    if (key_code !== 6'h00 || key_down !== 1'b0) begin
      bad++;
      $display("FAIL short_reset_clears code=%h d=%b exp code=00 d=0", key_code, key_down);
    end
    for (int n = 0; n < 161; n++) begin
      if (n == 32) keys = '0;
      if (n == 96) keys[2*8+5] = 1'b1;
      total++;
      if (key_valid !== 1'b0 || overrun !== 1'b0) begin
        bad++;
        $display("FAIL short_no_accept cyc=%0d v=%b o=%b exp v=0 o=0", n, key_valid, overrun);
      end
      step(1);
    end
    total++;
    if (key_valid !== 1'b1 || key_code !== 6'h15) begin
      bad++;
      $display("FAIL short_reaccept cyc=161 v=%b code=%h exp v=1 code=15", key_valid, key_code);
    end
    keys = '0;
  endtask

  task automatic test_multi();
    keys = '0;
    keys[1*8+0] = 1'b1;
    keys[6*8+7] = 1'b1;
    do_reset();
    step(64);
    total++;
    if (multi_press !== 1'b0) begin
      bad++;
      $display("FAIL multi_early cyc=64 m=%b exp=0", multi_press);
    end
    step(1);
    total++;
    if (multi_press !== 1'b1 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      bad++;
      $display("FAIL multi_set cyc=65 m=%b v=%b d=%b exp m=1 v=0 d=0",
               multi_press, key_valid, key_down);
    end
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    total++;
    if (multi_press !== 1'b0) begin
      bad++;
      $display("FAIL multi_ack m=%b exp=0", multi_press);
    end
    keys = '0;
  endtask

  task automatic test_overrun();
    keys = '0;
    keys[3*8+3] = 1'b1;
    do_reset();
    step(65);
    total++;
    if (key_valid !== 1'b1 || key_code !== 6'h1B) begin
      bad++;
      $display("FAIL ovr_first v=%b code=%h exp v=1 code=1B", key_valid, key_code);
    end
    keys = '0;
    step(63);
    total++;
    if (key_down !== 1'b1) begin
      bad++;
      $display("FAIL ovr_release_early cyc=128 d=%b exp=1", key_down);
    end
    step(1);
    total++;
    if (key_down !== 1'b0 || key_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovr_release cyc=129 d=%b v=%b exp d=0 v=1", key_down, key_valid);
    end
    keys[0*8+1] = 1'b1;
    step(63);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_early cyc=192 o=%b exp=0", overrun);
    end
    step(1);
    total++;
    if (overrun !== 1'b1 || key_code !== 6'h1B || key_valid !== 1'b1 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set cyc=193 o=%b code=%h v=%b d=%b exp o=1 code=1B v=1 d=1",
               overrun, key_code, key_valid, key_down);
    end
    keys = '0;
  endtask

  task automatic test_back_to_back();
    keys = '0;
    keys[3*8+3] = 1'b1;
    do_reset();
    step(65);
    keys = '0;
    step(64);
    total++;
    if (key_down !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release cyc=129 d=%b exp=0", key_down);
    end
    keys[0*8+1] = 1'b1;
    step(63);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    total++;
    if (key_code !== 6'h01 || key_valid !== 1'b1 || overrun !== 1'b0 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ack_accept code=%h v=%b o=%b d=%b exp code=01 v=1 o=0 d=1",
               key_code, key_valid, overrun, key_down);
    end
    keys = '0;
  endtask

  task automatic test_mid_reset();
    keys = '0;
    keys[4*8+2] = 1'b1;
    do_reset();
    step(22);
    total++;
    if (row !== 8'hDF) begin
      bad++;
      $display("FAIL midrst_row5 got=%h exp=DF", row);
    end
    reset = 1'b1;
    step(1);
    total++;
    if (row !== 8'hFE || {key_code, key_valid, key_down, multi_press, overrun} !== 10'd0) begin
      bad++;
      $display("FAIL midrst_state row=%h code=%h v=%b d=%b m=%b o=%b exp row=FE rest 0",
               row, key_code, key_valid, key_down, multi_press, overrun);
    end
    reset = 1'b0;
    step(64);
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_early cyc=64 v=%b exp=0", key_valid);
    end
    step(1);
    total++;
    if (key_valid !== 1'b1 || key_code !== 6'h22 || multi_press !== 1'b0) begin
      bad++;
      $display("FAIL midrst_accept v=%b code=%h m=%b exp v=1 code=22 m=0",
               key_valid, key_code, multi_press);
    end
    keys = '0;
  endtask

  initial begin
    reset   = 1'b1;
    key_ack = 1'b0;
    keys    = '0;
    test_reset();
    test_single_ack();
    test_short_press();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
